// File: rtl/mem_display_scanner_pkg.sv
// Shared definitions for the frame-synchronous memory-to-display copier.
// Holds the scan FSM state encoding and the default bus/row widths.
package mem_display_scanner_pkg;

  localparam int unsigned DefDigit     = 32;  // data word width
  localparam int unsigned DefAddrWidth = 8;   // probe word-address width
  localparam int unsigned DefRows      = 32;  // words copied per frame
  localparam int unsigned DefRowW      = 5;   // display-RAM row address width

  typedef enum logic [2:0] {
    StIdle,
    StLatch,
    StScan,
    StDrain,
    StDone
  } state_e;

endpackage

// File: rtl/mem_display_scanner_if.sv
// Memory-probe and display-RAM write bus of the scanner.
//   probe_addr : word address driven to the memory probe port
//   probe_data : probe read data, valid RD_LAT cycles after probe_addr
//   wr_en      : display-RAM write strobe
//   wr_addr    : display-RAM row address
//   wr_data    : display-RAM write data
// master = scanner side, slave = memory / display-RAM side.
interface mem_display_scanner_if
  import mem_display_scanner_pkg::*;
#(
  parameter int unsigned DIGIT     = DefDigit,
  parameter int unsigned ADDRWIDTH = DefAddrWidth,
  parameter int unsigned ROWW      = DefRowW
);

  logic [ADDRWIDTH-1:0] probe_addr;
  logic [DIGIT-1:0]     probe_data;
  logic                 wr_en;
  logic [ROWW-1:0]      wr_addr;
  logic [DIGIT-1:0]     wr_data;

  modport master (
    output probe_addr,
    input  probe_data,
    output wr_en,
    output wr_addr,
    output wr_data
  );

  modport slave (
    input  probe_addr,
    output probe_data,
    input  wr_en,
    input  wr_addr,
    input  wr_data
  );

endinterface

// File: rtl/mem_display_scanner_scan_valid_pipe.sv
// DEPTH-stage shift register carrying {valid, row} alongside the probe read latency,
// so each row tag emerges in the same cycle as its read data.
//   clock, reset : clock and asynchronous active-low clear
//   in_valid     : row tag pushed this cycle
//   in_row       : row index pushed
//   out_valid    : tag at the end of the pipe is valid
//   out_row      : row index at the end of the pipe
//   any_valid    : at least one stage holds a valid tag
module mem_display_scanner_scan_valid_pipe #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned ROWW  = 5
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  input  logic [ROWW-1:0] in_row,
  output logic            out_valid,
  output logic [ROWW-1:0] out_row,
  output logic            any_valid
);

  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [DEPTH*ROWW-1:0] row_q, row_d;

  // Stage 0 lives in the low bits; a single stage has nothing to shift.
  if (DEPTH == 1) begin : g_single
    assign valid_d = in_valid;
    assign row_d   = in_row;
  end else begin : g_multi
    assign valid_d = {valid_q[DEPTH-2:0], in_valid};
    assign row_d   = {row_q[(DEPTH-1)*ROWW-1:0], in_row};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      row_q   <= '0;
    end else begin
      valid_q <= valid_d;
      row_q   <= row_d;
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_row   = row_q[DEPTH*ROWW-1 -: ROWW];
  assign any_valid = |valid_q;

endmodule

// File: rtl/mem_display_scanner.sv
// Frame-synchronous copier: on each accepted frame-start it reads ROWS consecutive
// words from the memory probe port (starting at base_addr, wrapping modulo
// 2^ADDRWIDTH) and writes them into display-RAM rows 0..ROWS-1.
//   clock       : system clock
//   reset       : asynchronous active-low reset
//   enable      : gates acceptance of new frame_start pulses
//   frame_start : one-cycle start-of-vblank pulse
//   base_addr   : first memory word address to copy
//   bus         : probe read port and display-RAM write port (master side)
//   busy        : high from LATCH through DONE
//   done        : one-cycle pulse after the last write of a scan
//   frame_count : completed scans, wrapping
module mem_display_scanner
  import mem_display_scanner_pkg::*;
#(
  parameter int unsigned DIGIT     = DefDigit,
  parameter int unsigned ADDRWIDTH = DefAddrWidth,
  parameter int unsigned ROWS      = DefRows,
  parameter int unsigned ROWW      = DefRowW,
  parameter int unsigned RD_LAT    = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 frame_start,
  input  logic [ADDRWIDTH-1:0] base_addr,
  mem_display_scanner_if.master bus,
  output logic                 busy,
  output logic                 done,
  output logic [7:0]           frame_count
);

  localparam logic [ROWW-1:0] RowLast = ROWW'(ROWS - 1);

  state_e               state_q, state_d;
  logic [ADDRWIDTH-1:0] base_q;
  logic [ROWW-1:0]      idx_q;
  logic                 pending_q;
  logic [ADDRWIDTH-1:0] probe_addr_q;
  logic                 wr_en_q;
  logic [ROWW-1:0]      wr_addr_q;
  logic [DIGIT-1:0]     wr_data_q;
  logic [7:0]           frame_count_q;

  logic                 push;
  logic                 pipe_valid;
  logic [ROWW-1:0]      pipe_row;
  logic                 pipe_any;

  mem_display_scanner_scan_valid_pipe #(
    .DEPTH (RD_LAT),
    .ROWW  (ROWW)
  ) u_pipe (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (push),
    .in_row    (idx_q),
    .out_valid (pipe_valid),
    .out_row   (pipe_row),
    .any_valid (pipe_any)
  );

  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    unique case (state_q)
      StIdle:  if ((frame_start && enable) || pending_q) state_d = StLatch;
      StLatch: state_d = StScan;
      StScan: begin
        push = 1'b1;
        if (idx_q == RowLast) state_d = StDrain;
      end
      // Pipe empty means the last tag has been consumed by the write register,
      // whose output is visible this same cycle.
      StDrain: if (!pipe_any) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      base_q        <= '0;
      idx_q         <= '0;
      pending_q     <= 1'b0;
      probe_addr_q  <= '0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      frame_count_q <= '0;
    end else begin
      state_q <= state_d;

      // Pulses arriving while a scan is in flight collapse into one pending request.
      if (frame_start && enable && (state_q != StIdle)) begin
        pending_q <= 1'b1;
      end else if (state_q == StLatch) begin
        pending_q <= 1'b0;
      end

      // probe_addr is loaded with base in LATCH so address k is on the port
      // during SCAN cycle k, in step with the row tag pushed that cycle.
      if (state_q == StLatch) begin
        base_q       <= base_addr;
        idx_q        <= '0;
        probe_addr_q <= base_addr;
      end else if ((state_q == StScan) && (idx_q != RowLast)) begin
        idx_q        <= idx_q + 1'b1;
        probe_addr_q <= base_q + ADDRWIDTH'(idx_q) + ADDRWIDTH'(1);
      end

      wr_en_q <= pipe_valid;
      if (pipe_valid) begin
        wr_addr_q <= pipe_row;
        wr_data_q <= bus.probe_data;
      end

      if (state_q == StDone) frame_count_q <= frame_count_q + 8'd1;
    end
  end

  assign bus.probe_addr = probe_addr_q;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign busy           = (state_q != StIdle);
  assign done           = (state_q == StDone);
  assign frame_count    = frame_count_q;

endmodule
